// File: rtl/vend_controller.sv
// Vending controller: five-slot inventory, coin collection with timeout,
// one-cycle dispense/refund with registered strobes.
module vend_controller #(
  parameter int COIN_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [10:0] p0,
  input  logic [10:0] p1,
  input  logic [10:0] p2,
  input  logic [10:0] p3,
  input  logic [10:0] p4,
  input  logic        load,
  input  logic        select_valid,
  input  logic [2:0]  select_id,
  input  logic        coin_valid,
  input  logic [3:0]  coin_value,
  input  logic        cancel,
  output logic        dispense,
  output logic [2:0]  dispense_id,
  output logic        change_valid,
  output logic [4:0]  change,
  output logic        coin_reject,
  output logic        sold_out,
  output logic        error,
  output logic [4:0]  credit,
  output logic        busy,
  output logic [10:0] inv0,
  output logic [10:0] inv1,
  output logic [10:0] inv2,
  output logic [10:0] inv3,
  output logic [10:0] inv4
);

  localparam int TW = $clog2(COIN_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(COIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DISPENSE,
    REFUND
  } state_t;

  state_t        state;
  logic [10:0]   slot [5];
  logic [2:0]    sel_idx;
  logic [3:0]    price;
  logic [TW-1:0] tcnt;

  logic        hit;
  logic [2:0]  hit_idx;
  logic [10:0] hit_slot;
  logic [5:0]  sum;
  logic        accept;
  logic [4:0]  new_credit;
  logic        to_refund;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 4; i >= 0; i--) begin
      if (slot[i][10:8] == select_id) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  assign hit_slot   = slot[hit_idx];
  assign sum        = {1'b0, credit} + {2'b0, coin_value};
  assign accept     = coin_valid && !sum[5];
  assign new_credit = accept ? sum[4:0] : credit;
  assign to_refund  = cancel || (!accept && tcnt == TLAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      credit       <= '0;
      tcnt         <= '0;
      sel_idx      <= '0;
      price        <= '0;
      dispense     <= 1'b0;
      dispense_id  <= '0;
      change_valid <= 1'b0;
      change       <= '0;
      coin_reject  <= 1'b0;
      sold_out     <= 1'b0;
      error        <= 1'b0;
      for (int i = 0; i < 5; i++) slot[i] <= '0;
    end else begin
      dispense     <= 1'b0;
      dispense_id  <= '0;
      change_valid <= 1'b0;
      change       <= '0;
      coin_reject  <= coin_valid && state != COLLECT;
      sold_out     <= 1'b0;
      error        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            slot[0] <= p0;
            slot[1] <= p1;
            slot[2] <= p2;
            slot[3] <= p3;
            slot[4] <= p4;
          end else if (select_valid) begin
            if (!hit) begin
              error <= 1'b1;
            end else if (hit_slot[7:4] == 4'd0) begin
              sold_out <= 1'b1;
            end else begin
              sel_idx <= hit_idx;
              price   <= hit_slot[3:0];
              tcnt    <= '0;
              state   <= COLLECT;
            end
          end
        end
        COLLECT: begin
          coin_reject <= coin_valid && !accept;
          credit      <= new_credit;
          tcnt        <= accept ? '0 : tcnt + 1'b1;
          if (to_refund) begin
            change_valid <= 1'b1;
            change       <= new_credit;
            state        <= REFUND;
          end else if (new_credit >= {1'b0, price}) begin
            dispense     <= 1'b1;
            dispense_id  <= slot[sel_idx][10:8];
            change_valid <= 1'b1;
            change       <= new_credit - {1'b0, price};
            state        <= DISPENSE;
          end
        end
        DISPENSE: begin
          if (slot[sel_idx][7:4] != 4'd0)
            slot[sel_idx][7:4] <= slot[sel_idx][7:4] - 4'd1;
          credit <= '0;
          state  <= IDLE;
        end
        REFUND: begin
          credit <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign inv0 = slot[0];
  assign inv1 = slot[1];
  assign inv2 = slot[2];
  assign inv3 = slot[3];
  assign inv4 = slot[4];

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: directed vectors push expected
// strobe events; a negedge monitor pops and compares them.
module tb_vend_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [10:0] p0, p1, p2, p3, p4;
  logic        load, select_valid, coin_valid, cancel;
  logic [2:0]  select_id;
  logic [3:0]  coin_value;
  logic        dispense, change_valid, coin_reject, sold_out, error, busy;
  logic [2:0]  dispense_id;
  logic [4:0]  change, credit;
  logic [10:0] inv0, inv1, inv2, inv3, inv4;

  int tests = 0;
  int fails = 0;
  logic [12:0] exp_q[$];

  vend_controller #(.COIN_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4),
    .load(load), .select_valid(select_valid), .select_id(select_id),
    .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
    .dispense(dispense), .dispense_id(dispense_id),
    .change_valid(change_valid), .change(change),
    .coin_reject(coin_reject), .sold_out(sold_out), .error(error),
    .credit(credit), .busy(busy),
    .inv0(inv0), .inv1(inv1), .inv2(inv2), .inv3(inv3), .inv4(inv4)
  );

  always #5 clock = ~clock;

  function automatic logic [12:0] ev(logic d, logic [2:0] id, logic cv,
                                     logic [4:0] ch, logic rj, logic so,
                                     logic er);
    return {d, id, cv, ch, rj, so, er};
  endfunction

  // Monitor: every observed strobe cycle must match the next expectation.
  always @(negedge clock) begin
    logic [12:0] obs;
    obs = {dispense, dispense_id, change_valid, change,
           coin_reject, sold_out, error};
    if (dispense | change_valid | coin_reject | sold_out | error) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event got=%b required=none", obs);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        if (obs !== e) begin
          fails++;
          $display("FAIL event got=%b required=%b", obs, e);
        end
      end
    end else if (change !== 5'd0 || dispense_id !== 3'd0) begin
      tests++;
      fails++;
      $display("FAIL idle_data change=%0d id=%0d required=0", change,
               dispense_id);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    load = 0; select_valid = 0; coin_valid = 0; cancel = 0;
    select_id = 0; coin_value = 0;
  endtask

  task automatic sel(input logic [2:0] id);
    select_valid = 1; select_id = id;
    step();
  endtask

  task automatic coin(input logic [3:0] v);
    coin_valid = 1; coin_value = v;
    step();
  endtask

  initial begin
    reset = 1; load = 0; select_valid = 0; coin_valid = 0; cancel = 0;
    select_id = 0; coin_value = 0;
    p0 = 11'b011_0010_0101;
    p1 = 11'b101_0000_0010;
    p2 = 11'b011_0100_0001;
    p3 = 11'b001_0001_0011;
    p4 = 11'b110_0001_0111;
    step();
    step();
    reset = 0;
    chk("reset_credit", 32'(credit), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_inv0", 32'(inv0), 0);

    load = 1;
    step();
    chk("load_inv0", 32'(inv0), 32'h325);
    chk("load_inv4", 32'(inv4), 32'h617);

    // exact payment
    sel(3);
    chk("collect_busy", 32'(busy), 1);
    coin(2);
    chk("credit_2", 32'(credit), 2);
    exp_q.push_back(ev(1, 3, 1, 0, 0, 0, 0));
    coin(3);
    chk("dispense_credit", 32'(credit), 5);
    step();
    chk("exact_inv0", 32'(inv0), 32'h315);
    chk("exact_credit", 32'(credit), 0);
    chk("exact_busy", 32'(busy), 0);

    // overpay
    sel(3);
    exp_q.push_back(ev(1, 3, 1, 4, 0, 0, 0));
    coin(9);
    step();
    chk("over_credit", 32'(credit), 0);
    chk("over_inv0", 32'(inv0), 32'h305);

    // lowest slot with id 3 is empty; slot 2 must not be used
    exp_q.push_back(ev(0, 0, 0, 0, 0, 1, 0));
    sel(3);
    step();
    chk("soldout_busy", 32'(busy), 0);

    // load wins over simultaneous select (id 7 would error)
    load = 1; select_valid = 1; select_id = 7;
    step();
    chk("reload_inv0", 32'(inv0), 32'h325);

    // cancel with coin in same cycle
    sel(3);
    coin(2);
    exp_q.push_back(ev(0, 0, 1, 3, 0, 0, 0));
    cancel = 1;
    coin(1);
    step();
    chk("cancel_inv0", 32'(inv0), 32'h325);
    chk("cancel_credit", 32'(credit), 0);

    // unknown id, coin in IDLE, cancel in IDLE
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 1));
    sel(7);
    exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 0));
    coin(5);
    chk("idle_coin_credit", 32'(credit), 0);
    cancel = 1;
    step();
    step();

    // coin during DISPENSE is rejected
    sel(1);
    exp_q.push_back(ev(1, 1, 1, 0, 0, 0, 0));
    coin(3);
    exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 0));
    coin(4);
    step();
    chk("p3_count", 32'(inv3), 32'h103);
    chk("disp_coin_credit", 32'(credit), 0);

    // timeout refund
    sel(3);
    coin(1);
    repeat (14) step();
    chk("timeout_still_busy", 32'(busy), 1);
    exp_q.push_back(ev(0, 0, 1, 1, 0, 0, 0));
    step();
    step();
    chk("timeout_idle", 32'(busy), 0);

    // reset mid-COLLECT with credit held, overriding coin and cancel
    sel(3);
    coin(4);
    chk("pre_reset_credit", 32'(credit), 4);
    reset = 1; coin_valid = 1; coin_value = 1; cancel = 1;
    step();
    reset = 0;
    chk("rst_credit", 32'(credit), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_inv", 32'({inv0, inv1, inv2}), 0);
    chk("rst_inv34", 32'({inv3, inv4}), 0);

    repeat (3) step();
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
